// File: rtl/simon_serial_loader_if.sv
// Host/core-side signal bundle for the Simon serial loader.
interface simon_serial_loader_if;
  logic [1:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       core_valid;
  logic       data_out;
  logic [1:0] data_rdy;
  logic       busy;
  logic       done;
  logic       timeout;

  // Host / core side: drives commands, bytes and the core's valid flag.
  modport master (
    output cmd, cmd_valid, byte_in, byte_valid, core_valid,
    input  cmd_ready, byte_ready, data_out, data_rdy, busy, done, timeout
  );

  // Loader side.
  modport slave (
    input  cmd, cmd_valid, byte_in, byte_valid, core_valid,
    output cmd_ready, byte_ready, data_out, data_rdy, busy, done, timeout
  );
endinterface

// File: rtl/simon_serial_loader.sv
// Byte-wide front end for simon_module: serializes plaintext/key bytes MSB
// first onto data_out with the matching data_rdy mode code, and sequences the
// encrypt phase until the core reports valid or the timer expires.
module simon_serial_loader #(
  parameter int unsigned BLOCK_W     = 32,
  parameter int unsigned KEY_W       = 64,
  parameter int unsigned ENC_TIMEOUT = 1023
) (
  input logic                clk,
  input logic                reset,
  simon_serial_loader_if.slave bus
);

  localparam int unsigned BLK_BYTES = BLOCK_W / 8;
  localparam int unsigned KEY_BYTES = KEY_W / 8;
  localparam int unsigned MAX_BYTES = (BLK_BYTES > KEY_BYTES) ? BLK_BYTES : KEY_BYTES;
  localparam int unsigned BL_W      = $clog2(MAX_BYTES + 1);
  localparam int unsigned TMR_W     = $clog2(ENC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BYTE = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_ENCRYPT   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BL_W-1:0]   bytes_left_q, bytes_left_d;
  logic [1:0]        code_q, code_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              data_out_q, data_out_d;
  logic [1:0]        data_rdy_q, data_rdy_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              enc_done_c, enc_abort_c;
  logic              cmd_ready_c, byte_ready_c;

  // Handshake readiness decodes straight from the current state.
  assign cmd_ready_c  = (state_q == ST_IDLE);
  assign byte_ready_c = (state_q == ST_WAIT_BYTE) ||
                        ((state_q == ST_SHIFT) && (bit_cnt_q == 3'd7) &&
                         (bytes_left_q != '0));

  assign bus.cmd_ready  = cmd_ready_c;
  assign bus.byte_ready = byte_ready_c;
  assign bus.data_out   = data_out_q;
  assign bus.data_rdy   = data_rdy_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      bytes_left_q <= '0;
      code_q       <= '0;
      timer_q      <= '0;
      data_out_q   <= 1'b0;
      data_rdy_q   <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      bytes_left_q <= bytes_left_d;
      code_q       <= code_d;
      timer_q      <= timer_d;
      data_out_q   <= data_out_d;
      data_rdy_q   <= data_rdy_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    bytes_left_d = bytes_left_q;
    code_d       = code_q;
    timer_d      = timer_q;
    enc_done_c   = 1'b0;
    enc_abort_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            2'd1: begin
              state_d      = ST_WAIT_BYTE;
              code_d       = 2'd1;
              bytes_left_d = BL_W'(BLK_BYTES);
            end
            2'd2: begin
              state_d      = ST_WAIT_BYTE;
              code_d       = 2'd2;
              bytes_left_d = BL_W'(KEY_BYTES);
            end
            2'd3: begin
              state_d = ST_ENCRYPT;
              timer_d = '0;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT_BYTE: begin
        if (bus.byte_valid) begin
          shreg_d      = bus.byte_in;
          bytes_left_d = BL_W'(bytes_left_q - BL_W'(1));
          bit_cnt_d    = '0;
          state_d      = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d   = {shreg_q[6:0], 1'b0};
        bit_cnt_d = 3'(bit_cnt_q + 3'd1);
        if (bit_cnt_q == 3'd7) begin
          if (bytes_left_q != '0) begin
            // Reload on the last bit so consecutive bytes stream without a gap.
            if (bus.byte_valid) begin
              shreg_d      = bus.byte_in;
              bytes_left_d = BL_W'(bytes_left_q - BL_W'(1));
              bit_cnt_d    = '0;
            end else begin
              state_d = ST_WAIT_BYTE;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ENCRYPT: begin
        timer_d = TMR_W'(timer_q + TMR_W'(1));
        // core_valid takes priority over a timer expiring in the same cycle.
        if (bus.core_valid) begin
          enc_done_c = 1'b1;
          state_d    = ST_IDLE;
        end else if (timer_d == TMR_W'(ENC_TIMEOUT)) begin
          enc_abort_c = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs track the state being entered, so they align with it.
  always_comb begin
    data_out_d = 1'b0;
    data_rdy_d = 2'd0;
    busy_d     = (state_d != ST_IDLE);
    done_d     = enc_done_c;
    timeout_d  = enc_abort_c;
    if (state_d == ST_SHIFT) begin
      data_out_d = shreg_d[7];
      data_rdy_d = code_d;
    end else if (state_d == ST_ENCRYPT) begin
      data_rdy_d = 2'd3;
    end
  end

endmodule
